// File: rtl/pp_stream_pkg.sv
// pp_stream_pkg: shared FSM state type and default widths for the stream reader.
package pp_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DIM_WIDTH_DEF  = 12;
endpackage

// File: rtl/pp_axis_out_reg.sv
// pp_axis_out_reg: single-entry AXI4-Stream output register with load/handshake logic.
module pp_axis_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  last_in,
    input  logic                  user_in,
    input  logic                  tready,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    output logic                  tlast,
    output logic                  tuser
);
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;

    always_comb begin
        tvalid_d = load ? 1'b1 : (tready ? 1'b0 : tvalid_q);
        tdata_d  = load ? din : tdata_q;
        tlast_d  = load ? last_in : tlast_q;
        tuser_d  = load ? user_in : tuser_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign tdata  = tdata_q;
    assign tvalid = tvalid_q;
    assign tlast  = tlast_q;
    assign tuser  = tuser_q;
endmodule

// File: rtl/pp_fifo_to_axis_reader.sv
// pp_fifo_to_axis_reader: drains an FWFT FIFO into an AXI4-Stream video stream
// with per-line TLAST and start-of-frame TUSER.
module pp_fifo_to_axis_reader
    import pp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [DIM_WIDTH-1:0]  rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);
    state_e               state_q, state_d;
    logic [DIM_WIDTH-1:0] cols_q, cols_d, rows_q, rows_d;
    logic [DIM_WIDTH-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic                 pop, eol, eof;

    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        rows_d    = rows_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        pop = (state_q == RUN) && fifo_empty_n && (!m_axis_tvalid || m_axis_tready);
        eol = col_cnt_q == cols_q - DIM_WIDTH'(1);
        eof = eol && (row_cnt_q == rows_q - DIM_WIDTH'(1));
        case (state_q)
            IDLE: if (start) begin
                // zero-size frames skip straight to DONE so cols-1/rows-1 never underflow
                state_d   = (cols == '0 || rows == '0) ? DONE : RUN;
                cols_d    = cols;
                rows_d    = rows;
                col_cnt_d = '0;
                row_cnt_d = '0;
            end
            RUN: if (pop) begin
                col_cnt_d = eol ? '0 : col_cnt_q + DIM_WIDTH'(1);
                row_cnt_d = eol ? row_cnt_q + DIM_WIDTH'(1) : row_cnt_q;
                state_d   = eof ? DRAIN : RUN;
            end
            DRAIN: state_d = (m_axis_tvalid && m_axis_tready) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cols_q    <= '0;
            rows_q    <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cols_q    <= cols_d;
            rows_q    <= rows_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    assign fifo_read = pop;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;

    pp_axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk    (clk),
        .reset  (reset),
        .load   (pop),
        .din    (fifo_dout),
        .last_in(eol),
        .user_in(col_cnt_q == '0 && row_cnt_q == '0),
        .tready (m_axis_tready),
        .tdata  (m_axis_tdata),
        .tvalid (m_axis_tvalid),
        .tlast  (m_axis_tlast),
        .tuser  (m_axis_tuser)
    );
endmodule

// File: tb/tb_pp_fifo_to_axis_reader.sv
// tb_pp_fifo_to_axis_reader: directed self-checking bench with an FWFT FIFO model and AXIS sink.
module tb_pp_fifo_to_axis_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] cols = '0, rows = '0;
    logic        busy, done, fifo_empty_n, fifo_read;
    logic [15:0] fifo_dout, m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        m_axis_tready = 1'b1;

    logic [15:0] mem [0:15];
    int          wr_cnt = 0, rd_ptr = 0, pops = 0;
    logic        fifo_en = 1'b1, fifo_clr = 1'b0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    assign fifo_empty_n = fifo_en && (rd_ptr < wr_cnt);
    assign fifo_dout    = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= 0;
            pops   <= 0;
        end else if (fifo_read && fifo_empty_n) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    pp_fifo_to_axis_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cols         (cols),
        .rows         (rows),
        .busy         (busy),
        .done         (done),
        .fifo_empty_n (fifo_empty_n),
        .fifo_dout    (fifo_dout),
        .fifo_read    (fifo_read),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int base, input int n);
        fifo_clr = 1'b1;
        for (int i = 0; i < n; i++) mem[i] = 16'(base + i);
        wr_cnt = n;
        @(negedge clk);
        fifo_clr = 1'b0;
    endtask

    task automatic go(input int nc, input int nr);
        start = 1'b1;
        cols  = 12'(nc);
        rows  = 12'(nr);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // mode 1: tready pattern 1,0,0,1; starve>=0: FIFO hidden for 5 cycles; ign: mid-frame start
    task automatic collect(input int n, input int nc, input int base, input int mode,
                           input int starve, input bit ign);
        int          k = 0;
        bit          hs_prev = 0, stalled = 0, got_done = 0;
        logic [15:0] prev_data = '0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            m_axis_tready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            fifo_en = !(starve >= 0 && cyc >= starve && cyc < starve + 5);
            start = ign && cyc == 2;
            if (ign && cyc == 2) begin
                cols = 12'd1;
                rows = 12'd1;
            end
            if (starve >= 0 && cyc == starve + 2)
                check("starve_tvalid_low", {31'b0, m_axis_tvalid}, 32'd0);
            if (stalled) begin
                check("stall_tdata_hold", {16'b0, m_axis_tdata}, {16'b0, prev_data});
                check("stall_tvalid_hold", {31'b0, m_axis_tvalid}, 32'd1);
            end
            if (done) begin
                got_done = 1;
                check("done_after_last_hs", {31'b0, hs_prev}, 32'd1);
                check("beat_count_at_done", k, n);
            end else if (m_axis_tvalid && m_axis_tready) begin
                check("beat_tdata", {16'b0, m_axis_tdata}, base + k);
                check("beat_tlast", {31'b0, m_axis_tlast}, {31'b0, (k % nc) == nc - 1});
                check("beat_tuser", {31'b0, m_axis_tuser}, {31'b0, k == 0});
                k++;
                hs_prev = 1;
            end else begin
                hs_prev = 0;
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            @(negedge clk);
        end
        start = 1'b0;
        fifo_en = 1'b1;
        m_axis_tready = 1'b1;
        check("done_seen", {31'b0, got_done}, 32'd1);
        check("pop_count", pops, n);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("busy_low_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int hs, snap;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", {16'b0, m_axis_tdata}, 32'd0);
        check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        check("rst_tuser", {31'b0, m_axis_tuser}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_fifo_read", {31'b0, fifo_read}, 32'd0);

        load(1, 8);
        go(4, 2);
        collect(8, 4, 1, 0, -1, 0);

        load(1, 8);
        go(4, 2);
        collect(8, 4, 1, 1, -1, 0);

        load(1, 8);
        go(4, 2);
        collect(8, 4, 1, 0, 3, 0);

        load(1, 8);
        go(4, 2);
        collect(8, 4, 1, 0, -1, 1);

        load(1, 8);
        start = 1'b1;
        cols  = 12'd0;
        rows  = 12'd3;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", {31'b0, done}, 32'd1);
        check("zero_fifo_read", {31'b0, fifo_read}, 32'd0);
        check("zero_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        @(negedge clk);
        check("zero_done_drop", {31'b0, done}, 32'd0);
        check("zero_busy", {31'b0, busy}, 32'd0);
        check("zero_pops", pops, 0);

        load(1, 8);
        go(4, 2);
        hs = 0;
        for (int cyc = 0; cyc < 50 && hs < 3; cyc++) begin
            if (m_axis_tvalid && m_axis_tready) hs++;
            @(negedge clk);
        end
        check("rst_mid_hs", hs, 3);
        m_axis_tready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("mid_rst_tdata", {16'b0, m_axis_tdata}, 32'd0);
        check("mid_rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        check("mid_rst_tuser", {31'b0, m_axis_tuser}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_fifo_read", {31'b0, fifo_read}, 32'd0);
        snap = pops;
        reset = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_no_pops", pops, snap);
        check("mid_rst_idle_tvalid", {31'b0, m_axis_tvalid}, 32'd0);

        load(16'hA1, 2);
        go(2, 1);
        collect(2, 2, 16'hA1, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pp_fifo_to_axis_reader.md
# pp_fifo_to_axis_reader

Read-side bridge that drains an HLS-style FIFO (first-word-fall-through head, `empty_n`/`read` handshake) and emits the pixels as an AXI4-Stream video stream with per-line TLAST and start-of-frame TUSER. It sits at the output of the preprocessing pipeline, between the last internal stream FIFO and the DMA or stream interconnect. Frame geometry is latched per frame on `start`, and the block signals completion with a one-cycle `done` pulse.

## Interface
- DATA_WIDTH, 16, pixel/beat width; equals the FIFO data width.
- DIM_WIDTH, 12, width of the `cols`/`rows` inputs and the internal counters.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- cols  in  DIM_WIDTH  pixels per line; latched on accepted `start`.
- rows  in  DIM_WIDTH  lines per frame; latched on accepted `start`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- fifo_empty_n  in  1  FIFO head valid.
- fifo_dout  in  DATA_WIDTH  FIFO head data; valid whenever `fifo_empty_n`=1.
- fifo_read  out  1  pop request; the FIFO pops on the edge where `fifo_read` & `fifo_empty_n`.
- m_axis_tdata  out  DATA_WIDTH  pixel.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.

## Operation
- States:
  - IDLE: waits for `start`.
    - `start`=1 with `cols`=0 or `rows`=0 → DONE.
    - `start`=1 otherwise → RUN, with `cols`/`rows` latched and `col_cnt`=`row_cnt`=0.
  - RUN: pops FIFO words and loads them into the output register. Transitions to DRAIN on the pop of pixel (cols-1, rows-1).
  - DRAIN: waits until the last beat handshakes (`tvalid` & `tready`), then → DONE.
  - DONE: asserts `done` for 1 cycle, then → IDLE.
- Pop condition (combinational): `fifo_read` = (state==RUN) & `fifo_empty_n` & (!`m_axis_tvalid` | `m_axis_tready`).
- `fifo_read` is 0 in all other states. No words beyond cols*rows are ever popped.
- Output register update on each pop:
  - `tdata` ← `fifo_dout`
  - `tvalid` ← 1
  - `tlast` ← (`col_cnt`==cols-1)
  - `tuser` ← (`col_cnt`==0 & `row_cnt`==0)
- When a beat handshakes and there is no pop in the same cycle, `tvalid` ← 0.
- `tdata`/`tlast`/`tuser` are held stable while `tvalid`=1 and `tready`=0.
- Counters advance on each pop:
  - `col_cnt` wraps cols-1→0, and `row_cnt` increments on that wrap.
  - Counters are DIM_WIDTH wide. The end-of-line and end-of-frame compares use the latched values minus 1, computed in DIM_WIDTH unsigned arithmetic.
  - Zero-size frames are handled in IDLE and never reach that arithmetic.
- `start` in any state other than IDLE is ignored; the latched geometry is unaffected.
- Simultaneous events:
  - Handshake plus pop in the same cycle: the register is reloaded and `tvalid` stays 1, giving full throughput of 1 beat/cycle.
  - FIFO empty in RUN: no pop and no counter change. `tvalid` is deasserted after the pending beat is accepted.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0
  - `busy`=0, `done`=0, `fifo_read`=0
  - state=IDLE, counters=0
- `start` at cycle N → state RUN at N+1. The first pop can occur at N+1, and the first `tvalid` appears at N+2.
- Latency from FIFO pop to `tvalid` is 1 cycle.
- Sustained throughput is 1 beat/cycle when the FIFO is non-empty and `tready`=1.
- Last handshake at cycle M → `done`=1 at M+1, and `busy`=0 from M+2.
- Zero-size frame: `start` at N → `done` at N+1, with no `fifo_read` and no `tvalid`.
- `fifo_read` depends combinationally on `m_axis_tready`; the FIFO's `read` input tolerates this.
- Reset mid-frame: on the next edge, all outputs return to their reset values. Any beat in flight is dropped, and words remaining in the FIFO are not popped.

## Structure
- Package `pp_stream_pkg`:
  - state enum `{IDLE, RUN, DRAIN, DONE}`
  - default DATA_WIDTH and DIM_WIDTH constants
- Sub-module `pp_axis_out_reg`: the single-entry output register with load/handshake logic (`tdata`/`tlast`/`tuser`/`tvalid`). The top level contains the FSM, counters and pop logic.

## Test plan
- Basic frame: cols=4, rows=2, FIFO holds 0x0001..0x0008, `tready`=1.
  - 8 beats on consecutive cycles.
  - `tuser`=1 only on 0x0001; `tlast`=1 on 0x0004 and 0x0008.
  - `done` pulses 1 cycle after the 0x0008 handshake.
- Backpressure: same frame with `tready` toggling 1,0,0,1,…
  - `tdata` is stable while stalled, no pixel is lost or duplicated, and exactly 8 pops occur.
- FIFO starvation: `fifo_empty_n` low for 5 cycles mid-line.
  - `tvalid` drops after the pending beat and resumes with the correct pixel and `tlast` position.
- Zero size: `start` with cols=0, rows=3.
  - `done` on the next cycle; `fifo_read` and `tvalid` are never asserted.
- Reset mid-frame: reset after 3 of 8 beats.
  - All outputs return to 0 the next cycle, with no further pops.
  - A new `start` with cols=2, rows=1 then delivers 2 beats, with `tuser` on the first.
- Ignored start: pulse `start` with cols=1 during RUN of a 4×2 frame.
  - The frame still emits 8 beats with `tlast` every 4th beat.
